prng_share_ctrl: RTL and testbench

Shared controller for the team's 32-bit xorshift pseudo-random generator. Sits between one generator instance and NUM_REQ independent consumers, such as noise injection or dither blocks. It sequences seeding and warm-up, arbitrates round-robin among requesters, and advances the generator exactly once per granted draw. No two requesters ever receive the same value.

---
 rtl/prng_pkg.sv | 34 +++
 rtl/prng_share_ctrl_if.sv | 46 ++++
 rtl/xorshift32_core.sv | 57 +++++
 rtl/prng_share_ctrl.sv | 169 ++++++++++++++++
 tb/tb_prng_share_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the xorshift32 generator and its share controller:
//   - fsm_e             : controller states (WARM = discarding warm-up steps,
//                         SERVE = granting draws)
//   - PRNG_DEFAULT_SEED : seed used at reset and in place of a zero seed
//   - prng_step()       : one xorshift32 step with configurable shifts
// No ports (package).
// -----------------------------------------------------------------------------
package prng_pkg;

    typedef enum logic [0:0] {
        WARM  = 1'b0,
        SERVE = 1'b1
    } fsm_e;

    localparam logic [31:0] PRNG_DEFAULT_SEED = 32'hDEADBEEF;

    // The three shifts are applied in sequence within one combinational step;
    // bits shifted out of the 32-bit word are discarded.
    function automatic logic [31:0] prng_step(
        input logic [31:0] s,
        input int unsigned sa,
        input int unsigned sb,
        input int unsigned sc
    );
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = s ^ (s << sa);
        s2 = s1 ^ (s1 >> sb);
        return s2 ^ (s2 << sc);
    endfunction

endpackage

// File: rtl/prng_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// prng_share_ctrl_if
// Bundle between the requesters and the shared PRNG controller.
//   req        : per-requester level request (held until acked)
//   ack        : one-hot, one-cycle grant
//   rnd_out    : random value, meaningful only while any ack bit is set
//   seed_valid : load seed_data this cycle
//   seed_data  : new seed (zero selects the default seed)
//   ready      : warm-up complete, draws being served
//   draw_count : granted draws since reset, wraps modulo 2^32
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface prng_share_ctrl_if
    import prng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OUT_W   = 24
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [OUT_W-1:0]   rnd_out;
    logic               seed_valid;
    logic [31:0]        seed_data;
    logic               ready;
    logic [31:0]        draw_count;

    modport master (
        output req,
        output seed_valid,
        output seed_data,
        input  ack,
        input  rnd_out,
        input  ready,
        input  draw_count
    );

    modport slave (
        input  req,
        input  seed_valid,
        input  seed_data,
        output ack,
        output rnd_out,
        output ready,
        output draw_count
    );
endinterface

// File: rtl/xorshift32_core.sv
// -----------------------------------------------------------------------------
// xorshift32_core
// 32-bit xorshift state register.
//   clk, rst  : clock, asynchronous active-high reset (state <= SEED)
//   step_en   : advance the generator by one step
//   load_en   : load load_val (takes priority over step_en)
//   load_val  : seed to load; zero is replaced by SEED because zero is a
//               fixed point of xorshift
//   state     : current generator state
// -----------------------------------------------------------------------------
module xorshift32_core
    import prng_pkg::*;
#(
    parameter logic [31:0] SEED    = PRNG_DEFAULT_SEED,
    parameter int          SHIFT_A = 13,
    parameter int          SHIFT_B = 17,
    parameter int          SHIFT_C = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic        load_en,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    logic [31:0] state_r;
    logic [31:0] next_s;

    // Select next state: load (with zero-seed substitution), step, or hold.
    always_comb begin
        next_s = state_r;
        if (load_en) begin
            if (load_val == 32'd0) begin
                next_s = SEED;
            end else begin
                next_s = load_val;
            end
        end else if (step_en) begin
            next_s = prng_step(state_r, SHIFT_A, SHIFT_B, SHIFT_C);
        end else begin
            next_s = state_r;
        end
    end

    // Generator state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED;
        end else begin
            state_r <= next_s;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/prng_share_ctrl.sv
// -----------------------------------------------------------------------------
// prng_share_ctrl
// Shares one xorshift32 generator among NUM_REQ consumers. After reset or a
// reseed the generator is stepped WARMUP times with no grants (WARM), then
// requests are served round-robin, one draw per cycle (SERVE). Each grant
// steps the generator once, so no two grants ever see the same value.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : prng_share_ctrl_if.slave (req/ack/rnd_out/seed_valid/
//              seed_data/ready/draw_count), all outputs registered
// -----------------------------------------------------------------------------
module prng_share_ctrl
    import prng_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [31:0] SEED    = PRNG_DEFAULT_SEED,
    parameter int          SHIFT_A = 13,
    parameter int          SHIFT_B = 17,
    parameter int          SHIFT_C = 5,
    parameter int          WARMUP  = 4,
    parameter int          OUT_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    prng_share_ctrl_if.slave bus
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW   = RR_W + 1;

    fsm_e               fsm_r, fsm_next_s;
    logic [7:0]         cnt_r, cnt_next_s;
    logic [RR_W-1:0]    rr_r, rr_next_s;
    logic [NUM_REQ-1:0] ack_r, ack_next_s;
    logic [OUT_W-1:0]   rnd_r, rnd_next_s;
    logic               ready_r, ready_next_s;
    logic [31:0]        count_r, count_next_s;

    logic               step_en_s;
    logic               load_en_s;
    logic [31:0]        state_s;

    logic               found_s;
    logic [RR_W-1:0]    winner_s;
    logic [RR_W-1:0]    cand_s;
    logic [SW-1:0]      sum_s;

    xorshift32_core #(
        .SEED    (SEED),
        .SHIFT_A (SHIFT_A),
        .SHIFT_B (SHIFT_B),
        .SHIFT_C (SHIFT_C)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en_s),
        .load_en  (load_en_s),
        .load_val (bus.seed_data),
        .state    (state_s)
    );

    // Round-robin search: first requester at or after rr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {RR_W{1'b0}};
        cand_s   = {RR_W{1'b0}};
        sum_s    = {SW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, rr_r} + SW'(i);
            if (sum_s >= SW'(NUM_REQ)) begin
                cand_s = RR_W'(sum_s - SW'(NUM_REQ));
            end else begin
                cand_s = RR_W'(sum_s);
            end
            if (!found_s && bus.req[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and output logic; a reseed overrides any grant that cycle.
    always_comb begin
        fsm_next_s   = fsm_r;
        cnt_next_s   = cnt_r;
        rr_next_s    = rr_r;
        ack_next_s   = {NUM_REQ{1'b0}};
        rnd_next_s   = rnd_r;
        ready_next_s = ready_r;
        count_next_s = count_r;
        step_en_s    = 1'b0;
        load_en_s    = 1'b0;

        if (bus.seed_valid) begin
            load_en_s    = 1'b1;
            fsm_next_s   = WARM;
            cnt_next_s   = 8'd0;
            ready_next_s = 1'b0;
        end else begin
            case (fsm_r)
                WARM: begin
                    if (cnt_r == 8'(WARMUP)) begin
                        // Only reachable with WARMUP == 0: serve without stepping.
                        fsm_next_s   = SERVE;
                        ready_next_s = 1'b1;
                    end else begin
                        step_en_s  = 1'b1;
                        cnt_next_s = cnt_r + 8'd1;
                        if (({1'b0, cnt_r} + 9'd1) == 9'(WARMUP)) begin
                            fsm_next_s   = SERVE;
                            ready_next_s = 1'b1;
                        end else begin
                            fsm_next_s   = WARM;
                        end
                    end
                end
                SERVE: begin
                    if (found_s) begin
                        step_en_s            = 1'b1;
                        ack_next_s[winner_s] = 1'b1;
                        // Delivered value is the post-step state, same as the core loads.
                        rnd_next_s           = OUT_W'(prng_step(state_s, SHIFT_A, SHIFT_B, SHIFT_C));
                        count_next_s         = count_r + 32'd1;
                        if (winner_s == RR_W'(NUM_REQ - 1)) begin
                            rr_next_s = {RR_W{1'b0}};
                        end else begin
                            rr_next_s = winner_s + RR_W'(1);
                        end
                    end else begin
                        rr_next_s = rr_r;
                    end
                end
                default: begin
                    fsm_next_s   = WARM;
                    cnt_next_s   = 8'd0;
                    ready_next_s = 1'b0;
                end
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r   <= WARM;
            cnt_r   <= 8'd0;
            rr_r    <= {RR_W{1'b0}};
            ack_r   <= {NUM_REQ{1'b0}};
            rnd_r   <= {OUT_W{1'b0}};
            ready_r <= 1'b0;
            count_r <= 32'd0;
        end else begin
            fsm_r   <= fsm_next_s;
            cnt_r   <= cnt_next_s;
            rr_r    <= rr_next_s;
            ack_r   <= ack_next_s;
            rnd_r   <= rnd_next_s;
            ready_r <= ready_next_s;
            count_r <= count_next_s;
        end
    end

    assign bus.ack        = ack_r;
    assign bus.rnd_out    = rnd_r;
    assign bus.ready      = ready_r;
    assign bus.draw_count = count_r;

endmodule

// File: tb/tb_prng_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prng_share_ctrl
// Self-checking bench for prng_share_ctrl: a behavioural model (warm-up
// countdown, round-robin pick by modular search, xorshift step) is compared
// against the DUT every cycle, plus directed literal checks. A second
// instance with OUT_W=8 covers the narrow-output case.
// -----------------------------------------------------------------------------
module tb_prng_share_ctrl;
    import prng_pkg::*;

    localparam int          N     = 4;
    localparam int          OW    = 24;
    localparam int          WU    = 4;
    localparam logic [31:0] SEEDC = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prng_share_ctrl_if #(.NUM_REQ(N), .OUT_W(OW)) bus ();
    prng_share_ctrl_if #(.NUM_REQ(N), .OUT_W(8))  bus8 ();

    prng_share_ctrl #(
        .NUM_REQ(N), .SEED(SEEDC), .SHIFT_A(13), .SHIFT_B(17), .SHIFT_C(5),
        .WARMUP(WU), .OUT_W(OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prng_share_ctrl #(
        .NUM_REQ(N), .SEED(SEEDC), .SHIFT_A(13), .SHIFT_B(17), .SHIFT_C(5),
        .WARMUP(WU), .OUT_W(8)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    function automatic logic [31:0] ref_nstep(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = ref_step(t);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the main instance.
    logic [31:0]   m_state;
    int            m_warm_left;
    bit            m_serving;
    int            m_rr;
    logic [31:0]   m_count;
    logic [N-1:0]  m_ack;
    logic [OW-1:0] m_rnd;
    int            m_w;
    int            m_win;
    bit            m_found;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = SEEDC; m_warm_left = WU; m_serving = 0; m_rr = 0;
            m_count = 32'd0; m_ack = '0; m_rnd = '0;
        end else begin
            m_ack = '0;
            if (bus.seed_valid) begin
                m_state     = (bus.seed_data == 32'd0) ? SEEDC : bus.seed_data;
                m_serving   = 0;
                m_warm_left = WU;
            end else if (!m_serving) begin
                if (m_warm_left > 0) begin
                    m_state = ref_step(m_state);
                    m_warm_left--;
                end
                if (m_warm_left == 0) m_serving = 1;
            end else if (bus.req != '0) begin
                m_found = 0; m_win = 0;
                for (int i = 0; i < N; i++) begin
                    m_w = (m_rr + i) % N;
                    if (!m_found && bus.req[m_w]) begin m_found = 1; m_win = m_w; end
                end
                m_state      = ref_step(m_state);
                m_ack[m_win] = 1'b1;
                m_rnd        = m_state[OW-1:0];
                m_rr         = (m_win + 1) % N;
                m_count      = m_count + 32'd1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("cyc_ack",   64'(bus.ack),        64'(m_ack));
            chk("cyc_rnd",   64'(bus.rnd_out),    64'(m_rnd));
            chk("cyc_ready", 64'(bus.ready),      64'(m_serving));
            chk("cyc_count", 64'(bus.draw_count), 64'(m_count));
        end
    end

    initial begin
        logic [31:0] v;
        int waited;

        bus.req = '0;  bus.seed_valid = 1'b0;  bus.seed_data = 32'd0;
        bus8.req = '0; bus8.seed_valid = 1'b0; bus8.seed_data = 32'd0;

        // Pin the model's step function with hand-derived values.
        chk("pin_step1", 64'(ref_step(32'd1)), 64'h0000_0000_0004_2021);
        chk("pin_step2", 64'(ref_nstep(32'd1, 2)), 64'h0000_0000_0408_0601);
        chk("pin_step0", 64'(ref_step(32'd0)), 64'd0);

        #1 rst = 1'b1;
        #2;
        chk("rst_ack",   64'(bus.ack), 64'd0);
        chk("rst_rnd",   64'(bus.rnd_out), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_count", 64'(bus.draw_count), 64'd0);
        chk("rst_state", 64'(dut.u_core.state_r), 64'(SEEDC));
        #9 rst = 1'b0;
        run = 1'b1;

        // Warm-up with no requests.
        repeat (3) @(negedge clk);
        chk("warm_ready_low", 64'(bus.ready), 64'd0);
        @(negedge clk);
        chk("warm_ready_high", 64'(bus.ready), 64'd1);
        chk("warm_state", 64'(dut.u_core.state_r), 64'(ref_nstep(SEEDC, 4)));

        // All requesters active: strict rotation.
        bus.req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_order", 64'(bus.ack), 64'd1 << (k % 4));
            v = ref_nstep(SEEDC, 5 + k);
            chk("rr_rnd", 64'(bus.rnd_out), 64'(v[OW-1:0]));
            chk("rr_count", 64'(bus.draw_count), 64'(k + 1));
        end

        // Sparse requests: 2, then 0, then 2 (pointer wraps).
        bus.req = 4'b0100;
        @(negedge clk); chk("sparse_a", 64'(bus.ack), 64'h4);
        bus.req = 4'b0101;
        @(negedge clk); chk("sparse_b", 64'(bus.ack), 64'h1);
        @(negedge clk); chk("sparse_c", 64'(bus.ack), 64'h4);
        bus.req = 4'b0000;
        @(negedge clk); chk("idle_ack", 64'(bus.ack), 64'd0);
        chk("idle_count", 64'(bus.draw_count), 64'd9);

        // Zero reseed with requests pending.
        bus.req = 4'b1111; bus.seed_valid = 1'b1; bus.seed_data = 32'd0;
        @(negedge clk);
        bus.seed_valid = 1'b0;
        chk("reseed_ack",   64'(bus.ack), 64'd0);
        chk("reseed_ready", 64'(bus.ready), 64'd0);
        chk("reseed_state", 64'(dut.u_core.state_r), 64'(SEEDC));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("reseed_warm_ack", 64'(bus.ack), 64'd0);
        end
        @(negedge clk);
        chk("reseed_resume", 64'(bus.ack), 64'h8);

        // Randomised traffic with occasional reseeds.
        for (int k = 0; k < 300; k++) begin
            bus.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) begin
                bus.seed_valid = 1'b1;
                bus.seed_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            end else begin
                bus.seed_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.seed_valid = 1'b0;

        // Asynchronous reset in the middle of a grant stream.
        bus.req = 4'b1111;
        repeat (8) @(negedge clk);
        chk("pre_rst_active", 64'(bus.ack != '0), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack",   64'(bus.ack), 64'd0);
        chk("arst_rnd",   64'(bus.rnd_out), 64'd0);
        chk("arst_count", 64'(bus.draw_count), 64'd0);
        chk("arst_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("replay_ack", 64'(bus.ack), 64'd1 << k);
            v = ref_nstep(SEEDC, 5 + k);
            chk("replay_rnd", 64'(bus.rnd_out), 64'(v[OW-1:0]));
        end
        bus.req = '0;

        // Narrow output instance: seed 1, single request.
        bus8.seed_valid = 1'b1; bus8.seed_data = 32'd1;
        @(negedge clk);
        bus8.seed_valid = 1'b0; bus8.req = 4'b0001;
        waited = 0;
        while (bus8.ack == '0 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        chk("w8_latency", 64'(waited), 64'd5);
        chk("w8_ack", 64'(bus8.ack), 64'h1);
        v = ref_nstep(32'd1, 5);
        chk("w8_rnd", 64'(bus8.rnd_out), 64'(v[7:0]));
        bus8.req = '0;
        @(negedge clk);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
